// File: rtl/bp_arbiter.sv
// Round-robin, packet-aware arbiter merging N_SRC length-prefixed BytePipe
// sources onto one downstream BytePipe; a grant is held for a whole packet.
module bp_arbiter #(
  parameter  int N_SRC   = 4,
  localparam int SRCID_W = $clog2(N_SRC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic [8*N_SRC-1:0]   i_src_data,
  input  logic [N_SRC-1:0]     i_src_valid,
  output logic [N_SRC-1:0]     o_src_ready,
  output logic [7:0]           o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  output logic                 o_busy,
  output logic [SRCID_W-1:0]   o_grantIdx
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [SRCID_W-1:0]   grant_q, grant_d;
  logic [7:0]           rem_q, rem_d;
  logic                 hdr_q, hdr_d;

  logic                 sel_found;
  logic [SRCID_W-1:0]   sel_idx;
  logic [7:0]           g_byte;
  logic                 xfer;
  int unsigned          gi;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rem_d       = rem_q;
    hdr_d       = hdr_q;
    o_src_ready = '0;
    o_bp_valid  = 1'b0;
    o_bp_data   = '0;
    sel_found   = 1'b0;
    sel_idx     = grant_q;
    gi          = int'(grant_q);
    g_byte      = i_src_data[8*gi +: 8];
    xfer        = i_cg & i_src_valid[gi] & i_bp_ready;

    unique case (state_q)
      IDLE: begin
        // Scan upward from the last grant so the previous winner has lowest priority.
        for (int unsigned off = 1; off <= N_SRC; off++) begin
          if (!sel_found && i_src_valid[(gi + off) % N_SRC]) begin
            sel_found = 1'b1;
            sel_idx   = SRCID_W'((gi + off) % N_SRC);
          end
        end
        if (i_cg && sel_found) begin
          grant_d = sel_idx;
          state_d = BURST;
          hdr_d   = 1'b1;
        end
      end
      BURST: begin
        o_bp_data       = g_byte;
        o_bp_valid      = i_cg & i_src_valid[gi];
        o_src_ready[gi] = i_cg & i_bp_ready;
        if (xfer) begin
          if (hdr_q) begin
            if (g_byte == 8'd0) begin
              state_d = IDLE;
            end else begin
              rem_d = g_byte;
              hdr_d = 1'b0;
            end
          end else begin
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= SRCID_W'(N_SRC - 1);
      rem_q   <= '0;
      hdr_q   <= 1'b0;
    end else if (i_cg) begin
      state_q <= state_d;
      grant_q <= grant_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
    end
  end

  assign o_busy     = (state_q == BURST);
  assign o_grantIdx = grant_q;

endmodule

// File: tb/tb_bp_arbiter.sv
// Scoreboard bench for bp_arbiter: source queues feed the DUT, expected
// {source,byte} pairs are queued in arbitration order and popped per transfer.
module tb_bp_arbiter;

  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic           i_cg  = 1'b1;
  logic [8*N-1:0] i_src_data = '0;
  logic [N-1:0]   i_src_valid = '0;
  logic [N-1:0]   o_src_ready;
  logic [7:0]     o_bp_data;
  logic           o_bp_valid;
  logic           i_bp_ready = 1'b1;
  logic           o_busy;
  logic [1:0]     o_grantIdx;

  bp_arbiter #(.N_SRC(N)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cg        (i_cg),
    .i_src_data  (i_src_data),
    .i_src_valid (i_src_valid),
    .o_src_ready (o_src_ready),
    .o_bp_data   (o_bp_data),
    .o_bp_valid  (o_bp_valid),
    .i_bp_ready  (i_bp_ready),
    .o_busy      (o_busy),
    .o_grantIdx  (o_grantIdx)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] srcq [N][$];
  int         exp_q [$];
  int         xcyc [$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         tog = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_src_valid[k]       = (srcq[k].size() > 0);
      i_src_data[8*k +: 8] = (srcq[k].size() > 0) ? srcq[k][0] : 8'h00;
    end
  endtask

  // One clock: observe at negedge, advance sources just after posedge.
  task automatic step();
    logic [N-1:0] hs;
    int           e;
    hs = '0;
    @(negedge i_clk);
    if (i_cg && !i_rst && o_busy && exp_q.size() > 0)
      chk("src_ready", int'(o_src_ready), i_bp_ready ? (1 << (exp_q[0] / 256)) : 0);
    if (o_bp_valid && i_bp_ready && i_cg && !i_rst) begin
      xcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", int'(o_grantIdx) * 256 + int'(o_bp_data), 'hFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer", int'(o_grantIdx) * 256 + int'(o_bp_data), e);
      end
    end
    for (int k = 0; k < N; k++)
      if (i_src_valid[k] && o_src_ready[k] && i_cg && !i_rst) hs[k] = 1'b1;
    @(posedge i_clk);
    cyc++;
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
    if (tog) i_bp_ready = ~i_bp_ready;
    drive();
  endtask

  task automatic src_pkt(input int k, input int len, input int base);
    srcq[k].push_back(8'(len));
    for (int i = 0; i < len; i++) srcq[k].push_back(8'(base + 'h11 * i));
  endtask

  task automatic exp_pkt(input int k, input int len, input int base, input int nb);
    for (int i = 0; i < nb; i++)
      exp_q.push_back(k * 256 + ((i == 0) ? len : ((base + 'h11 * (i - 1)) & 255)));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() > 0 || o_busy); i++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic rst_and_check();
    for (int k = 0; k < N; k++) srcq[k].delete();
    exp_q.delete();
    tog        = 1'b0;
    i_bp_ready = 1'b1;
    i_cg       = 1'b1;
    drive();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    xcyc.delete();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_bp_valid, 0);
    chk("rst_ready", int'(o_src_ready), 0);
    chk("rst_data", o_bp_data, 0);
    chk("rst_grant", o_grantIdx, 3);
  endtask

  initial begin
    int c0, bad, n0;

    // Single source, 1-cycle arbitration latency, back-to-back bytes
    rst_and_check();
    c0 = cyc;
    src_pkt(0, 2, 'hAA);
    exp_pkt(0, 2, 'hAA, 3);
    drive();
    chk("idle_valid", o_bp_valid, 0);
    step();
    chk("lat_valid", o_bp_valid, 1);
    drain();
    chk("t1_count", xcyc.size(), 3);
    if (xcyc.size() == 3) begin
      chk("t1_first", xcyc[0], c0 + 1);
      chk("t1_span", xcyc[2] - xcyc[0], 2);
    end
    chk("t1_busy", o_busy, 0);
    chk("t1_grant", o_grantIdx, 0);

    // Contention: round-robin order 0,1,2,3,0,... with one bubble per packet
    rst_and_check();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) src_pkt(k, 1, k + 'h40 * r);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) exp_pkt(k, 1, k + 'h40 * r, 2);
    drive();
    drain();
    chk("rr_count", xcyc.size(), 16);
    bad = 0;
    for (int i = 0; i + 1 < xcyc.size(); i++)
      if (xcyc[i+1] - xcyc[i] != ((i % 2 == 0) ? 1 : 2)) bad++;
    chk("rr_gaps", bad, 0);

    // Zero-length packet followed by re-grant of the sole requester
    rst_and_check();
    src_pkt(2, 0, 0);
    src_pkt(2, 1, 'h55);
    exp_pkt(2, 0, 0, 1);
    exp_pkt(2, 1, 'h55, 2);
    drive();
    drain();
    chk("z_count", xcyc.size(), 3);
    if (xcyc.size() == 3) begin
      chk("z_bubble", xcyc[1] - xcyc[0], 2);
      chk("z_next", xcyc[2] - xcyc[1], 1);
    end
    chk("z_grant", o_grantIdx, 2);

    // Backpressure: downstream ready toggles every cycle
    rst_and_check();
    tog = 1'b1;
    src_pkt(1, 3, 'h11);
    exp_pkt(1, 3, 'h11, 4);
    drive();
    drain();
    tog = 1'b0;
    i_bp_ready = 1'b1;
    chk("bp_count", xcyc.size(), 4);
    bad = 0;
    for (int i = 0; i + 1 < xcyc.size(); i++)
      if (xcyc[i+1] - xcyc[i] != 2) bad++;
    chk("bp_gaps", bad, 0);

    // Clock gate held low mid-packet
    rst_and_check();
    src_pkt(3, 5, 'h10);
    exp_pkt(3, 5, 'h10, 6);
    drive();
    for (int i = 0; i < 20 && xcyc.size() < 2; i++) step();
    chk("cg_pre", xcyc.size(), 2);
    n0 = xcyc.size();
    i_cg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cg_valid", o_bp_valid, 0);
      chk("cg_ready", int'(o_src_ready), 0);
      chk("cg_busy", o_busy, 1);
    end
    chk("cg_noxfer", xcyc.size(), n0);
    chk("cg_grant", o_grantIdx, 3);
    i_cg = 1'b1;
    drain();
    chk("cg_count", xcyc.size(), 6);
    chk("cg_done", o_busy, 0);

    // Reset after header and two payload bytes, then a fresh packet
    rst_and_check();
    src_pkt(0, 5, 'hA0);
    exp_pkt(0, 5, 'hA0, 3);
    drive();
    for (int i = 0; i < 20 && xcyc.size() < 3; i++) step();
    chk("mr_pre", xcyc.size(), 3);
    i_bp_ready = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_bp_ready = 1'b1;
    chk("mr_busy", o_busy, 0);
    chk("mr_valid", o_bp_valid, 0);
    chk("mr_grant", o_grantIdx, 3);
    srcq[0].delete();
    src_pkt(0, 1, 'h77);
    exp_pkt(0, 1, 'h77, 2);
    drive();
    drain();
    chk("mr_count", xcyc.size(), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_arbiter.md
Name: bp_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one downstream BytePipe between N_SRC BytePipe sources.
- Typical use: several bpCorrelator-class engines, or engine plus status reporter, sharing a single ptyBytePipe/USB link.
- Packets are length-prefixed: header byte L, followed by L payload bytes.
- A grant is held until the whole packet has transferred, so packets never interleave.

Parameters:
- N_SRC, 4, number of requesting sources; legal range 2..16.
- SRCID_W, $clog2(N_SRC), width of the grant index; derived, not overridden.

Ports:
- i_clk  input  1  sole clock.
- i_rst  input  1  synchronous, active-high reset.
- i_cg  input  1  clock gate; when low, no transfer occurs and all state holds.
- i_src_data  input  8*N_SRC  source byte; source k occupies bits [8k+7:8k].
- i_src_valid  input  N_SRC  per-source valid.
- o_src_ready  output  N_SRC  per-source ready.
- o_bp_data  output  8  downstream byte.
- o_bp_valid  output  1  downstream valid.
- i_bp_ready  input  1  downstream ready.
- o_busy  output  1  high while a packet is in progress (state BURST).
- o_grantIdx  output  SRCID_W  index of the current or last granted source.

Behaviour:
- Transfer: a byte moves on a port only when valid & ready & i_cg are all high on the same i_clk edge.
- States: IDLE, BURST.
- Reset (i_rst high at a clk edge, regardless of i_cg):
  - state=IDLE, o_grantIdx=N_SRC-1, so source 0 has first priority.
  - Remaining-byte counter rem=0.
  - o_busy=0, o_bp_valid=0, o_src_ready=0, o_bp_data=0.
- IDLE:
  - o_bp_valid=0, o_src_ready=0, o_bp_data=0.
  - If i_cg and any i_src_valid is high: select the first valid source scanning upward, with wrap, from o_grantIdx+1 mod N_SRC.
  - Register the selection into o_grantIdx and go to BURST next cycle.
  - Arbitration latency is exactly 1 cycle. No byte moves in the decision cycle.
- BURST, with g = o_grantIdx:
  - Combinational datapath: o_bp_data=i_src_data[g], o_bp_valid=i_src_valid[g], o_src_ready[g]=i_bp_ready. All other o_src_ready bits are 0.
  - No buffering; zero-latency pass-through; full throughput of 1 byte/cycle.
  - Phase flag hdr, set on entry to BURST:
    - Header transfer with L=0: return to IDLE.
    - Header transfer with L>0: rem<=L, clear hdr.
  - Each payload transfer decrements rem. The transfer with rem==1 returns to IDLE.
  - o_src_valid of other sources is ignored during BURST; requests are never dropped, they wait.
- Back-to-back packets:
  - The IDLE decision cycle always sits between packets, giving 1 bubble cycle per packet.
  - If the same source is the only requester, it is re-granted.
- Fairness: any continuously-valid source is granted within N_SRC-1 packets of others.
- Grant source drops i_src_valid mid-packet: the arbiter stays in BURST and waits indefinitely. The protocol forbids abandoning packets.
- i_bp_ready low: hold; the source sees ready low.
- i_cg low:
  - No state, counter, or grant change.
  - All o_src_ready and o_bp_valid are forced to 0, so no byte is counted on either side.
- Reset mid-packet: abort immediately; the next packet starts fresh from IDLE.
  - Downstream may receive a truncated packet; this is accepted, since the host resyncs on reset.
- Counter width: 8 bits; L=255 is legal, giving a 256-byte packet.

Test Plan:
- Single source: src0 sends [02,AA,BB] with ready always high. Response:
  - o_bp_valid rises 1 cycle after src0 valid.
  - Output is 02,AA,BB on consecutive cycles.
  - o_busy falls after BB; o_grantIdx=0.
- Contention: all 4 sources continuously valid, each sending [01,k]. Response:
  - Grant order is 0,1,2,3,0.
  - Each packet is 2 output bytes followed by 1 bubble cycle.
  - No interleaving of bytes from different sources.
- Zero-length packet: src2 sends [00] then [01,55]. Response:
  - Output is 00, a bubble, then 01,55.
  - src2 is re-granted when it is the sole requester.
- Backpressure: src1 sends [03,11,22,33] while i_bp_ready toggles 1,0,1,0. Response:
  - Bytes advance only on ready-high cycles.
  - o_src_ready[1] mirrors i_bp_ready.
  - Exactly 4 transfers occur.
- Clock gate: i_cg=0 for 5 cycles in the middle of a packet. Response:
  - Zero transfers; rem and o_grantIdx are unchanged.
  - Packet resumes and completes correctly once i_cg returns high.
- Reset mid-packet: assert i_rst after the header (05) and 2 payload bytes. Response, next cycle:
  - o_busy=0, o_bp_valid=0, o_grantIdx=3.
  - A fresh [01,77] from src0 transfers correctly.
